// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
//   Shared types and helpers for the pushbutton conditioning block.
//   - db_state_e : debounce FSM state (2-bit encoding)
//   - cnt_width  : counter width for a cycle count, never less than 1 bit
// -----------------------------------------------------------------------------
package button_debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Width needed to hold 0..n-1; a 1-cycle count still needs one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : button_debounce_pkg

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchroniser for a single asynchronous pin.
//   Ports:
//     clk      in  system clock
//     reset_n  in  asynchronous active-low reset
//     d_i      in  asynchronous input
//     q_o      out synchronised output (two clk edges of latency)
//   Parameter RESET_VAL sets the value both flops take in reset.
// -----------------------------------------------------------------------------
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // NOTE: clocked state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff_q <= {2{RESET_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule : sync2

// File: rtl/button_debounce_toggle.sv
// -----------------------------------------------------------------------------
// button_debounce_toggle
//   Conditions one raw pushbutton / slide switch: synchronise, debounce, and
//   produce a clean level, press/release/long-press strobes and a toggle bit.
//   Ports:
//     clk              in  system clock
//     reset_n          in  asynchronous active-low reset
//     btn_raw          in  raw pin, asynchronous to clk
//     clear_toggle     in  synchronous clear of toggle_out (wins over a press)
//     level_out        out debounced level, 1 = pressed
//     toggle_out       out flips on every committed press
//     press_pulse      out one-cycle strobe on committed press
//     release_pulse    out one-cycle strobe on committed release
//     long_press_pulse out one-cycle strobe, at most once per press
//   All outputs are registered.
// -----------------------------------------------------------------------------
module button_debounce_toggle
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic clear_toggle,
  output logic level_out,
  output logic toggle_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  // Pressed-is-1 view of the pin, then synchronised into clk.
  logic btn_b;
  logic btn_s;

  assign btn_b = ACTIVE_LOW ? ~btn_raw : btn_raw;

  sync2 #(.RESET_VAL(1'b0)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (btn_b),
    .q_o     (btn_s)
  );

  db_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_fired_q, long_fired_d;
  logic              level_q, level_d;
  logic              toggle_q, toggle_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  logic press_evt;
  logic release_evt;
  logic long_evt;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;

    unique case (state_q)
      ST_RELEASED: begin
        if (btn_s) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = ST_RELEASED;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_s) state_d = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = ST_RELEASED;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RELEASED;
    endcase

    // Any state change restarts the debounce window.
    if (state_d != state_q) cnt_d = '0;

    // Hold time keeps counting through a release bounce; it only restarts
    // on a fresh committed press.
    hold_d = hold_q;
    if (press_evt) begin
      hold_d = '0;
    end else if ((state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) &&
                 (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end

    long_evt     = (hold_q == HOLD_MAX) && !long_fired_q;
    long_fired_d = long_fired_q;
    if (press_evt)     long_fired_d = 1'b0;
    else if (long_evt) long_fired_d = 1'b1;

    level_d = level_q;
    if (press_evt)        level_d = 1'b1;
    else if (release_evt) level_d = 1'b0;

    // Clear takes priority over a same-edge press toggle.
    toggle_d = toggle_q;
    if (clear_toggle)   toggle_d = 1'b0;
    else if (press_evt) toggle_d = ~toggle_q;

    press_d   = press_evt;
    release_d = release_evt;
    long_d    = long_evt;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RELEASED;
      cnt_q        <= '0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      toggle_q     <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      toggle_q     <= toggle_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
    end
  end

  assign level_out        = level_q;
  assign toggle_out       = toggle_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;

endmodule : button_debounce_toggle

// File: tb/tb_button_debounce_toggle.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_toggle
//   Directed bench for button_debounce_toggle with DEBOUNCE_CYCLES=4,
//   LONG_PRESS_CYCLES=10, ACTIVE_LOW=1. Inputs change 1 time unit after a
//   rising edge, so a new btn_raw value is first sampled on the next edge
//   (called e0). Outputs are read 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_button_debounce_toggle;

  localparam int DB = 4;
  localparam int LP = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b1;
  logic clear_toggle = 1'b0;
  logic level_out, toggle_out, press_pulse, release_pulse, long_press_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_tog = 1'b0;

  int press_cnt = 0;
  int release_cnt = 0;
  int long_cnt = 0;
  int both_cnt = 0;

  button_debounce_toggle #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .ACTIVE_LOW        (1'b1)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .btn_raw          (btn_raw),
    .clear_toggle     (clear_toggle),
    .level_out        (level_out),
    .toggle_out       (toggle_out),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse)
  );

  always #5 clk = ~clk;

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (press_pulse)                  press_cnt++;
    if (release_pulse)                release_cnt++;
    if (long_press_pulse)             long_cnt++;
    if (press_pulse && release_pulse) both_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press from idle: btn_raw low from e0; checks edges e0..e0+7.
  task automatic press_seq(input string tag);
    logic want_p, want_l, want_t;
    btn_raw = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      step();
      want_p = (k == DB + 2);
      want_l = (k >= DB + 2);
      want_t = (k >= DB + 2) ? ~exp_tog : exp_tog;
      n_cmp++;
      if (press_pulse !== want_p) begin
        n_bad++;
        $display("FAIL %s press_pulse k=%0d got %b want %b", tag, k, press_pulse, want_p);
      end
      n_cmp++;
      if (level_out !== want_l) begin
        n_bad++;
        $display("FAIL %s level_out k=%0d got %b want %b", tag, k, level_out, want_l);
      end
      n_cmp++;
      if (toggle_out !== want_t) begin
        n_bad++;
        $display("FAIL %s toggle_out k=%0d got %b want %b", tag, k, toggle_out, want_t);
      end
    end
    exp_tog = ~exp_tog;
  endtask

  // Release from pressed: btn_raw high from r0; checks edges r0..r0+7.
  task automatic release_seq(input string tag);
    logic want_r, want_l;
    btn_raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      want_r = (k == DB + 2);
      want_l = (k < DB + 2);
      n_cmp++;
      if (release_pulse !== want_r) begin
        n_bad++;
        $display("FAIL %s release_pulse k=%0d got %b want %b", tag, k, release_pulse, want_r);
      end
      n_cmp++;
      if (level_out !== want_l) begin
        n_bad++;
        $display("FAIL %s level_out k=%0d got %b want %b", tag, k, level_out, want_l);
      end
      n_cmp++;
      if (press_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL %s press_pulse during release k=%0d got %b want 0", tag, k, press_pulse);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({level_out, toggle_out, press_pulse, release_pulse, long_press_pulse} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset outputs got %b want 00000",
               {level_out, toggle_out, press_pulse, release_pulse, long_press_pulse});
    end
    repeat (3) step();
    reset_n = 1'b1;
    repeat (4) step();
    n_cmp++;
    if ({level_out, toggle_out, press_pulse, release_pulse, long_press_pulse} !== 5'b0) begin
      n_bad++;
      $display("FAIL post_reset idle outputs got %b want 00000",
               {level_out, toggle_out, press_pulse, release_pulse, long_press_pulse});
    end
  endtask

  task automatic test_clean_press();
    press_seq("clean1_press");
    release_seq("clean1_release");
    press_seq("clean2_press");
    release_seq("clean2_release");
  endtask

  task automatic test_press_bounce();
    logic want_p;
    // Pressed 3 samples, released 1, then pressed steadily (final low at e0+4).
    btn_raw = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      step();
      if (k == 2) btn_raw = 1'b1;
      if (k == 3) btn_raw = 1'b0;
      want_p = (k == 10);
      n_cmp++;
      if (press_pulse !== want_p) begin
        n_bad++;
        $display("FAIL press_bounce press_pulse k=%0d got %b want %b", k, press_pulse, want_p);
      end
    end
    n_cmp++;
    if (toggle_out !== ~exp_tog) begin
      n_bad++;
      $display("FAIL press_bounce toggle_out got %b want %b", toggle_out, ~exp_tog);
    end
    exp_tog = ~exp_tog;
    release_seq("press_bounce_release");

    // A 3-sample glitch alone must not commit.
    btn_raw = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      step();
      if (k == 2) btn_raw = 1'b1;
      n_cmp++;
      if ({level_out, press_pulse} !== 2'b00) begin
        n_bad++;
        $display("FAIL glitch level/press k=%0d got %b want 00", k, {level_out, press_pulse});
      end
    end
  endtask

  task automatic test_release_bounce();
    logic want_r;
    press_seq("rel_bounce_press");
    // Released 2 samples, pressed 1, then released steadily.
    btn_raw = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step();
      if (k == 1) btn_raw = 1'b0;
      if (k == 2) btn_raw = 1'b1;
      want_r = (k == 9);
      n_cmp++;
      if (release_pulse !== want_r) begin
        n_bad++;
        $display("FAIL rel_bounce release_pulse k=%0d got %b want %b", k, release_pulse, want_r);
      end
      n_cmp++;
      if (press_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL rel_bounce press_pulse k=%0d got %b want 0", k, press_pulse);
      end
    end
  endtask

  task automatic test_long_press();
    logic want_lp;
    int base;
    press_seq("long_press");
    // press_seq returns one edge after press_pulse (j = 1).
    base = long_cnt;
    for (int j = 2; j <= 30; j++) begin
      step();
      want_lp = (j == LP);
      n_cmp++;
      if (long_press_pulse !== want_lp) begin
        n_bad++;
        $display("FAIL long_press pulse j=%0d got %b want %b", j, long_press_pulse, want_lp);
      end
    end
    release_seq("long_release");
    repeat (4) step();
    n_cmp++;
    if (long_cnt - base !== 1) begin
      n_bad++;
      $display("FAIL long_press count got %0d want 1", long_cnt - base);
    end

    // Raw press of 8 samples: released well before the hold threshold.
    base = long_cnt;
    press_seq("short_press");
    release_seq("short_release");
    repeat (8) step();
    n_cmp++;
    if (long_cnt - base !== 0) begin
      n_bad++;
      $display("FAIL short_press long count got %0d want 0", long_cnt - base);
    end
  endtask

  task automatic test_clear_toggle();
    logic want_p;
    press_seq("clear_prep_press");
    release_seq("clear_prep_release");
    clear_toggle = 1'b1;
    step();
    clear_toggle = 1'b0;
    n_cmp++;
    if (toggle_out !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_toggle plain got %b want 0", toggle_out);
    end
    exp_tog = 1'b0;

    // Clear on the same edge as the committed press.
    btn_raw = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k == DB + 1) clear_toggle = 1'b1;
      if (k == DB + 2) clear_toggle = 1'b0;
      want_p = (k == DB + 2);
      n_cmp++;
      if (press_pulse !== want_p) begin
        n_bad++;
        $display("FAIL clear_same_edge press_pulse k=%0d got %b want %b", k, press_pulse, want_p);
      end
      n_cmp++;
      if (toggle_out !== 1'b0) begin
        n_bad++;
        $display("FAIL clear_same_edge toggle_out k=%0d got %b want 0", k, toggle_out);
      end
    end
    release_seq("clear_release");
  endtask

  task automatic test_reset_mid();
    press_seq("rst_prep_press");
    release_seq("rst_prep_release");
    // PRESS_WAIT is entered at e0+2; cnt is 2 after e0+4.
    btn_raw = 1'b0;
    for (int k = 0; k <= 4; k++) step();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({level_out, toggle_out, press_pulse, release_pulse, long_press_pulse} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_mid outputs got %b want 00000",
               {level_out, toggle_out, press_pulse, release_pulse, long_press_pulse});
    end
    exp_tog = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    // Button still held: the first post-reset sample is the next edge.
    press_seq("reset_mid_press");
    release_seq("reset_mid_release");
  endtask

  task automatic test_totals();
    n_cmp++;
    if (both_cnt !== 0) begin
      n_bad++;
      $display("FAIL press_and_release_together got %0d want 0", both_cnt);
    end
    n_cmp++;
    if (press_cnt !== 10) begin
      n_bad++;
      $display("FAIL total_press_pulses got %0d want 10", press_cnt);
    end
    n_cmp++;
    if (release_cnt !== 10) begin
      n_bad++;
      $display("FAIL total_release_pulses got %0d want 10", release_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_long_press();
    test_clear_toggle();
    test_reset_mid();
    repeat (4) step();
    test_totals();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_button_debounce_toggle

// File: doc/button_debounce_toggle.md
# button_debounce_toggle

Conditions one raw mechanical pushbutton or slide switch for the CodecAudio Qsys system. It synchronises the pin, debounces it, and produces a clean level, one-cycle press/release/long-press strobes, and a press-toggled state bit. `toggle_out` drives the `in_port` of the ToggleAccMat PIO, whose falling-edge capture then interrupts the Nios on each second press.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000, number of cycles the synchronised input must be stable before a change is committed (10 ms at 50 MHz). Legal range ≥ 2.
- `LONG_PRESS_CYCLES`, 50000000, number of cycles of committed press before `long_press_pulse` fires (1 s). Legal range ≥ 2.
- `ACTIVE_LOW`, 1, set to 1 when the pin reads 0 while pressed (DE-series KEY).

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `btn_raw`  in  1  raw pin, asynchronous to `clk`
- `clear_toggle`  in  1  synchronous clear of `toggle_out`
- `level_out`  out  1  debounced level, 1 = pressed
- `toggle_out`  out  1  flips on every committed press
- `press_pulse`  out  1  one-cycle strobe on committed press
- `release_pulse`  out  1  one-cycle strobe on committed release
- `long_press_pulse`  out  1  one-cycle strobe, at most once per press

## Operation
- Polarity: `b = ACTIVE_LOW ? ~btn_raw : btn_raw`. `b` feeds a 2-FF synchroniser that resets to 0. The synchroniser output is `s`.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. The debounce counter `cnt` is cleared on every state change.
  - RELEASED: if `s`=1, go to PRESS_WAIT.
  - PRESS_WAIT: if `s`=0, go to RELEASED (bounce; no outputs change). If `s`=1 and `cnt`=DEBOUNCE_CYCLES-1, go to PRESSED. Otherwise increment `cnt`.
  - PRESSED: if `s`=0, go to RELEASE_WAIT.
  - RELEASE_WAIT: if `s`=1, go to PRESSED (bounce; no strobe). If `s`=0 and `cnt`=DEBOUNCE_CYCLES-1, go to RELEASED. Otherwise increment `cnt`.
- Transition PRESS_WAIT→PRESSED, all on the same edge:
  - `level_out` goes to 1.
  - `press_pulse` goes to 1.
  - `toggle_out` inverts.
  - `hold` is cleared.
  - `long_fired` is cleared.
- Transition RELEASE_WAIT→RELEASED, on the same edge: `level_out` goes to 0 and `release_pulse` goes to 1.
- Hold counter `hold`:
  - Increments while in PRESSED or RELEASE_WAIT. It is not reset by a release bounce.
  - Saturates at LONG_PRESS_CYCLES-1.
  - At the cycle where `hold`=LONG_PRESS_CYCLES-1 and `long_fired`=0: assert `long_press_pulse` and set `long_fired`.
- `clear_toggle` forces `toggle_out` to 0 and wins over a simultaneous press toggle. `press_pulse` is still emitted in that case.
- Width rules:
  - `cnt` width: $clog2(DEBOUNCE_CYCLES).
  - `hold` width: $clog2(LONG_PRESS_CYCLES).
  - Both are unsigned and never wrap.

## Timing
- Reset values: all outputs 0, FSM in RELEASED, `cnt`=`hold`=0, `long_fired`=0.
- Press latency: `b` is first sampled 1 at edge e0. `level_out`, `press_pulse` and `toggle_out` change at edge e0+DEBOUNCE_CYCLES+2, provided `s` stays 1 throughout. Release latency is identical.
- `long_press_pulse` fires LONG_PRESS_CYCLES cycles after `press_pulse`.
- All strobes last exactly 1 cycle. `press_pulse` and `release_pulse` are never asserted together.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous). A button held through reset release produces a normal press after DEBOUNCE_CYCLES+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `button_debounce_pkg`:
  - FSM state enum (2-bit encoding).
  - Function `cnt_width(n)`, wrapping $clog2 with a minimum of 1.
- Sub-module `sync2`: a 2-FF synchroniser with an asynchronous reset and a reset-value parameter. It is reused for other pin inputs.
- The top level holds the FSM, the two counters, and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1.
- Clean press: `btn_raw` goes 1→0 and is first sampled at edge e0 -> `level_out`=1, `press_pulse` high for exactly 1 cycle at e0+6, `toggle_out` 0→1. A second press/release pair -> `toggle_out` returns to 0.
- Press bounce: `btn_raw` is low for 3 cycles, high for 1, then low steadily -> one `press_pulse` only, at 6 cycles after the final low is sampled. A 3-cycle glitch alone -> no output change.
- Release bounce: held pressed, then high 2 cycles / low 1 / high steadily -> exactly one `release_pulse`, and no second `press_pulse`.
- Long press: held 30 cycles past `press_pulse` -> exactly one `long_press_pulse`, 10 cycles after `press_pulse`. A press released after 8 cycles -> no `long_press_pulse`.
- `clear_toggle` asserted on the same edge as `press_pulse`, with `toggle_out`=0 -> `toggle_out` stays 0 and `press_pulse`=1.
- `reset_n` pulsed low while in PRESS_WAIT with `cnt`=2 -> all outputs 0 at once; after release with the button still held, `press_pulse` occurs 6 cycles later.
